// File: rtl/cpu_ctrl_fsm.sv
// Purpose : instruction sequencer (fetch/decode/exec/mem/wb) with a req/ready memory handshake.
// Latency : NOP/JMP 2 cycles, STORE 3, MOV/ADD/LOAD 4, plus one cycle per memory wait state.
// Backpr. : holds FETCH/MEM while i_mem_ready=0; after MEM_TIMEOUT waiting cycles goes to ERROR.
//
// Ports:
//   i_clk, i_reset (sync, active-low), i_start (leave IDLE)
//   i_opcode/i_operand : instruction word, captured on a FETCH handshake
//   i_mem_ready        : memory completes the current request
//   o_mem_req/o_mem_we/o_mem_addr : memory request
//   o_alu_en, o_reg_we : datapath strobes
//   o_pc, o_state, o_instr_count, o_halted, o_illegal, o_timeout : status
module cpu_ctrl_fsm #(
    parameter int OPCODE_W    = 8,
    parameter int ADDR_W      = 8,
    parameter int STATE_W     = 8,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [ADDR_W-1:0]   i_operand,
    input  logic                i_mem_ready,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_alu_en,
    output logic                o_reg_we,
    output logic [ADDR_W-1:0]   o_pc,
    output logic [STATE_W-1:0]  o_state,
    output logic [CNT_W-1:0]    o_instr_count,
    output logic                o_halted,
    output logic                o_illegal,
    output logic                o_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    // Full-width compares: with OPCODE_W > 8 anything above 0xFF falls to illegal.
    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(8'h00);
    localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(8'h01);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(8'h02);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(8'h03);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(8'h04);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(8'h05);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(8'hFF);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [OPCODE_W-1:0] r_ir_op;
    logic [ADDR_W-1:0]   r_ir_arg;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_illegal;
    logic                r_timeout;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_alu_en;
    logic                r_reg_we;
    logic                r_halted;
    logic [STATE_W-1:0]  r_state_out;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [OPCODE_W-1:0] w_op_nxt;
    logic [ADDR_W-1:0]   w_arg_nxt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_retire;
    logic                w_illegal_nxt;
    logic                w_timeout_nxt;
    logic                w_wait_last;

    // Counter holds the number of cycles already spent waiting; this is the
    // last cycle on which a late mem_ready may still complete the access.
    assign w_wait_last = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_op_nxt      = r_ir_op;
        w_arg_nxt     = r_ir_arg;
        w_wait_nxt    = '0;
        w_retire      = 1'b0;
        w_illegal_nxt = r_illegal;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (i_mem_ready) begin
                    w_op_nxt    = i_opcode;
                    w_arg_nxt   = i_operand;
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_state_nxt = S_DECODE;
                end else if (w_wait_last) begin
                    w_state_nxt   = S_ERROR;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (r_ir_op == OP_NOP) begin
                    w_state_nxt = S_FETCH;
                    w_retire    = 1'b1;
                end else if (r_ir_op == OP_MOV || r_ir_op == OP_ADD) begin
                    w_state_nxt = S_EXEC;
                end else if (r_ir_op == OP_LOAD || r_ir_op == OP_STORE) begin
                    w_state_nxt = S_MEM;
                end else if (r_ir_op == OP_JMP) begin
                    w_pc_nxt    = r_ir_arg;
                    w_state_nxt = S_FETCH;
                    w_retire    = 1'b1;
                end else if (r_ir_op == OP_HALT) begin
                    w_state_nxt = S_HALT;
                    w_retire    = 1'b1;
                end else begin
                    w_state_nxt   = S_ERROR;
                    w_illegal_nxt = 1'b1;
                end
            end
            S_EXEC: w_state_nxt = S_WB;
            S_MEM: begin
                if (i_mem_ready) begin
                    if (r_ir_op == OP_STORE) begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_wait_last) begin
                    w_state_nxt   = S_ERROR;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = r_state;   // HALT and ERROR hold until reset
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // r_state and never see the inputs combinationally.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_ir_op     <= '0;
            r_ir_arg    <= '0;
            r_wait      <= '0;
            r_cnt       <= '0;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_alu_en    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_halted    <= 1'b0;
            r_state_out <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir_op   <= w_op_nxt;
            r_ir_arg  <= w_arg_nxt;
            r_wait    <= w_wait_nxt;
            r_illegal <= w_illegal_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_retire && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_mem_req   <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM);
            r_mem_we    <= (w_state_nxt == S_MEM) && (w_op_nxt == OP_STORE);
            r_mem_addr  <= (w_state_nxt == S_MEM) ? w_arg_nxt : w_pc_nxt;
            r_alu_en    <= (w_state_nxt == S_EXEC);
            r_reg_we    <= (w_state_nxt == S_WB);
            r_halted    <= (w_state_nxt == S_HALT);
            r_state_out <= STATE_W'(w_state_nxt);
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_alu_en      = r_alu_en;
    assign o_reg_we      = r_reg_we;
    assign o_pc          = r_pc;
    assign o_state       = r_state_out;
    assign o_instr_count = r_cnt;
    assign o_halted      = r_halted;
    assign o_illegal     = r_illegal;
    assign o_timeout     = r_timeout;

endmodule
